// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW scoreboard, memory freeze,
// EX redirect squash, stall-cycle counter and sticky memory-timeout flag.
module pipe_hazard_ctrl #(
   parameter bit          RF_BYPASS   = 1'b0,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [2:0]       id_src1,
   input  logic             id_src1_vld,
   input  logic [2:0]       id_src2,
   input  logic             id_src2_vld,
   input  logic [2:0]       id_dst,
   input  logic             id_dst_vld,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_done,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_bubble,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             raw_stall,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_err
);

   localparam int unsigned REG_W  = 3;
   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] rnum;
   } tag_t;

   typedef enum logic {
      ST_IDLE,
      ST_MEM_WAIT
   } state_t;

   state_t            state_q, state_d;
   tag_t              tag_ex_q, tag_ex_d;
   tag_t              tag_mem_q, tag_mem_d;
   tag_t              tag_wb_q, tag_wb_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              mem_err_q, mem_err_d;

   logic              freeze;
   logic              hit1;
   logic              hit2;
   logic              raw_hit;

   // RAW compare of ID sources against in-flight destinations
   always_comb begin
      hit1 = (tag_ex_q.vld  && (tag_ex_q.rnum  == id_src1)) ||
             (tag_mem_q.vld && (tag_mem_q.rnum == id_src1)) ||
             (!RF_BYPASS && tag_wb_q.vld && (tag_wb_q.rnum == id_src1));
      hit2 = (tag_ex_q.vld  && (tag_ex_q.rnum  == id_src2)) ||
             (tag_mem_q.vld && (tag_mem_q.rnum == id_src2)) ||
             (!RF_BYPASS && tag_wb_q.vld && (tag_wb_q.rnum == id_src2));
      raw_hit = id_valid && ((id_src1_vld && hit1) || (id_src2_vld && hit2));
   end

   // Memory-wait FSM; freeze covers every cycle the access is still outstanding
   always_comb begin
      state_d = state_q;
      freeze  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_req && !mem_done) begin
               state_d = ST_MEM_WAIT;
               freeze  = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_done) begin
               state_d = ST_IDLE;
            end else begin
               freeze  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pipeline control; freeze wins, and a frozen EX re-presents its redirect later
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      raw_stall   = 1'b0;
      if (freeze) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (ex_redirect) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (raw_hit) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
         raw_stall   = 1'b1;
      end
   end

   // Scoreboard advances with the pipeline; bubbles and squashes enter as invalid
   always_comb begin
      tag_ex_d  = tag_ex_q;
      tag_mem_d = tag_mem_q;
      tag_wb_d  = tag_wb_q;
      if (!freeze) begin
         tag_wb_d  = tag_mem_q;
         tag_mem_d = tag_ex_q;
         if (raw_stall || ex_redirect || !id_valid || !id_dst_vld) begin
            tag_ex_d = '0;
         end else begin
            tag_ex_d.vld  = 1'b1;
            tag_ex_d.rnum = id_dst;
         end
      end
   end

   // Saturating stall counter, wait-cycle counter and sticky timeout flag
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      wait_cnt_d  = '0;
      mem_err_d   = mem_err_q;
      if ((freeze || raw_stall) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((state_q == ST_MEM_WAIT) && !mem_done) begin
         if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            wait_cnt_d = wait_cnt_q;
            mem_err_d  = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         tag_ex_q    <= '0;
         tag_mem_q   <= '0;
         tag_wb_q    <= '0;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tag_ex_q    <= tag_ex_d;
         tag_mem_q   <= tag_mem_d;
         tag_wb_q    <= tag_wb_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two instances (no bypass / write-through RF) share stimulus and
// are checked every cycle against a sliding-window reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned TMO = 8;

   logic clk;
   logic rst;
   logic id_valid;
   logic [2:0] id_src1;
   logic id_src1_vld;
   logic [2:0] id_src2;
   logic id_src2_vld;
   logic [2:0] id_dst;
   logic id_dst_vld;
   logic ex_redirect;
   logic mem_req;
   logic mem_done;

   logic [1:0] pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
   logic [1:0] exmem_en, memwb_en, raw_stall, mem_err;
   logic [15:0] stall_cnt0;
   logic [4:0]  stall_cnt1;

   pipe_hazard_ctrl #(.RF_BYPASS(1'b0), .MEM_TIMEOUT(TMO), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_src1(id_src1), .id_src1_vld(id_src1_vld),
      .id_src2(id_src2), .id_src2_vld(id_src2_vld),
      .id_dst(id_dst), .id_dst_vld(id_dst_vld),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_done(mem_done),
      .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
      .idex_en(idex_en[0]), .idex_bubble(idex_bubble[0]),
      .exmem_en(exmem_en[0]), .memwb_en(memwb_en[0]), .raw_stall(raw_stall[0]),
      .stall_cnt(stall_cnt0), .mem_err(mem_err[0]));

   pipe_hazard_ctrl #(.RF_BYPASS(1'b1), .MEM_TIMEOUT(TMO), .CNT_W(5)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_src1(id_src1), .id_src1_vld(id_src1_vld),
      .id_src2(id_src2), .id_src2_vld(id_src2_vld),
      .id_dst(id_dst), .id_dst_vld(id_dst_vld),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_done(mem_done),
      .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
      .idex_en(idex_en[1]), .idex_bubble(idex_bubble[1]),
      .exmem_en(exmem_en[1]), .memwb_en(memwb_en[1]), .raw_stall(raw_stall[1]),
      .stall_cnt(stall_cnt1), .mem_err(mem_err[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] ctl;
      int         cnt;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: destinations of the last three advancing ID slots, newest first
   int win[2][3];
   bit in_wait[2];
   int waited[2];
   bit err[2];
   int cnt[2];
   int cmax[2];

   function automatic bit in_window(input int k, input logic [2:0] s);
      int r = int'(s);
      return (win[k][0] == r) || (win[k][1] == r) || ((k == 0) && (win[k][2] == r));
   endfunction

   task automatic model_cycle(input int k);
      bit frz, raw, rstall;
      exp_t e;
      int nd;
      if (!rst) begin
         for (int i = 0; i < 3; i++) win[k][i] = -1;
         in_wait[k] = 0; waited[k] = 0; err[k] = 0; cnt[k] = 0;
      end
      frz = in_wait[k] ? !mem_done : (mem_req && !mem_done);
      raw = id_valid && ((id_src1_vld && in_window(k, id_src1)) ||
                         (id_src2_vld && in_window(k, id_src2)));
      // bit order: pc ifid_en ifid_flush idex_en idex_bubble exmem memwb raw_stall mem_err
      if (frz)              e.ctl = {8'b0000_0000, err[k]};
      else if (ex_redirect) e.ctl = {8'b1111_1110, err[k]};
      else if (raw)         e.ctl = {8'b0001_1111, err[k]};
      else                  e.ctl = {8'b1101_0110, err[k]};
      e.cnt = cnt[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      if (rst) begin
         rstall = !frz && !ex_redirect && raw;
         if (!frz) begin
            nd = (rstall || ex_redirect || !id_valid || !id_dst_vld) ? -1 : int'(id_dst);
            win[k][2] = win[k][1];
            win[k][1] = win[k][0];
            win[k][0] = nd;
         end
         if ((frz || rstall) && (cnt[k] < cmax[k])) cnt[k]++;
         if (in_wait[k]) begin
            if (mem_done) begin
               in_wait[k] = 0; waited[k] = 0;
            end else begin
               waited[k]++;
               if (waited[k] >= int'(TMO)) err[k] = 1;
            end
         end else if (mem_req && !mem_done) begin
            in_wait[k] = 1; waited[k] = 0;
         end
      end
   endtask

   task automatic step();
      model_cycle(0);
      model_cycle(1);
      @(negedge clk);
   endtask

   task automatic cyc(input logic v, input logic [2:0] s1, input logic s1v,
                      input logic [2:0] s2, input logic s2v, input logic [2:0] d,
                      input logic dv, input logic redir, input logic req, input logic done);
      id_valid = v; id_src1 = s1; id_src1_vld = s1v; id_src2 = s2; id_src2_vld = s2v;
      id_dst = d; id_dst_vld = dv; ex_redirect = redir; mem_req = req; mem_done = done;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   logic [8:0] act0, act1;
   assign act0 = {pc_en[0], ifid_en[0], ifid_flush[0], idex_en[0], idex_bubble[0],
                  exmem_en[0], memwb_en[0], raw_stall[0], mem_err[0]};
   assign act1 = {pc_en[1], ifid_en[1], ifid_flush[1], idex_en[1], idex_bubble[1],
                  exmem_en[1], memwb_en[1], raw_stall[1], mem_err[1]};

   // Monitor: outputs are presented every cycle; pop one expectation per instance
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (act0 !== e.ctl) begin
               errors++;
               $display("FAIL ctl_nobyp t=%0t got=%b exp=%b", $time, act0, e.ctl);
            end
            checks++;
            if (stall_cnt0 !== 16'(e.cnt)) begin
               errors++;
               $display("FAIL stall_cnt_nobyp t=%0t got=%0d exp=%0d", $time, stall_cnt0, e.cnt);
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (act1 !== e.ctl) begin
               errors++;
               $display("FAIL ctl_byp t=%0t got=%b exp=%b", $time, act1, e.ctl);
            end
            checks++;
            if (stall_cnt1 !== 5'(e.cnt)) begin
               errors++;
               $display("FAIL stall_cnt_byp t=%0t got=%0d exp=%0d", $time, stall_cnt1, e.cnt);
            end
         end
      end
   end

   initial begin
      int guard;
      cmax[0] = 65535;
      cmax[1] = 31;
      rst = 1'b0;
      id_valid = 0; id_src1 = 0; id_src1_vld = 0; id_src2 = 0; id_src2_vld = 0;
      id_dst = 0; id_dst_vld = 0; ex_redirect = 0; mem_req = 0; mem_done = 0;
      @(negedge clk);
      idle(2);
      rst = 1'b1;
      idle(2);

      // producer r3, then a dependent consumer held in ID through its stall
      cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 3, 1, 1, 0, 4, 1, 0, 0, 0);
      idle(3);

      // four-cycle memory freeze, then completion
      cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 6, 1, 7, 1, 1, 1, 0, 1, 0);
      cyc(1, 6, 1, 7, 1, 1, 1, 0, 1, 1);
      idle(3);

      // redirect in the same cycle as a RAW hit
      cyc(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      cyc(1, 2, 1, 0, 0, 4, 1, 1, 0, 0);
      idle(3);

      // redirect held across a freeze, taking effect on the completion cycle
      cyc(1, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      idle(3);

      // matching tag but source not read, then ID not valid
      cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      cyc(1, 5, 0, 5, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      cyc(0, 5, 1, 5, 1, 0, 0, 0, 0, 0);
      idle(3);

      // timeout, then reset mid-wait
      for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      rst = 1'b1;
      idle(3);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) != 0);
         cyc(($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      end
      rst = 1'b1;
      idle(2);

      guard = 0;
      while (((q0.size() > 0) || (q1.size() > 0)) && (guard < 10)) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if ((q0.size() > 0) || (q1.size() > 0)) begin
         errors++;
         $display("FAIL drain got=%0d/%0d pending exp=0", q0.size(), q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage WISC pipeline (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of in-flight destination registers and compares it against the decoded sources of the instruction in ID.
- Freezes the whole pipeline during multi-cycle data-memory accesses.
- Squashes younger instructions on an EX-stage redirect.
- Drives every pipeline-register enable, bubble and flush, and exports a stall-cycle counter and a memory-timeout error.

Parameters:
RF_BYPASS, 0, 1 = register file is write-through, so the WB-stage tag is excluded from the RAW compare.
MEM_TIMEOUT, 64, number of MEM_WAIT cycles after which mem_err sets.
CNT_W, 16, width of stall_cnt.

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_src1  in  3  first source register
id_src1_vld  in  1  id_src1 is read
id_src2  in  3  second source register
id_src2_vld  in  1  id_src2 is read
id_dst  in  3  destination register
id_dst_vld  in  1  instruction writes id_dst
ex_redirect  in  1  branch/jump resolved taken in EX
mem_req  in  1  MEM stage holds a load/store
mem_done  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  load NOP into IF/ID
idex_en  out  1  ID/EX register enable
idex_bubble  out  1  load NOP into ID/EX
exmem_en  out  1  EX/MEM register enable
memwb_en  out  1  MEM/WB register enable
raw_stall  out  1  RAW hazard stall active this cycle
stall_cnt  out  CNT_W  saturating count of stall and freeze cycles
mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Scoreboard: tag_ex, tag_mem and tag_wb, each {vld, reg[2:0]}. r0 is a real register and is compared like any other.
- hit(s) = tag_ex.vld & tag_ex.reg==s | tag_mem.vld & tag_mem.reg==s | (!RF_BYPASS & tag_wb.vld & tag_wb.reg==s).
- raw_hit = id_valid & ((id_src1_vld & hit(id_src1)) | (id_src2_vld & hit(id_src2))).
- FSM states: IDLE, MEM_WAIT.
  - IDLE -> MEM_WAIT when mem_req & !mem_done.
  - MEM_WAIT -> IDLE when mem_done.
  - A zero-wait access (mem_req & mem_done in IDLE) stays in IDLE with no freeze.
- freeze = (IDLE & mem_req & !mem_done) | (MEM_WAIT & !mem_done). Combinational; the mem_done cycle is not frozen.
- Priority: freeze > ex_redirect > raw_hit.
  - freeze: all five enables = 0; flush and bubble = 0; scoreboard holds. ex_redirect is ignored, because the frozen EX stage re-presents it.
  - redirect (no freeze): pc_en = ifid_en = idex_en = exmem_en = memwb_en = 1; ifid_flush = 1; idex_bubble = 1; raw_stall = 0.
  - raw stall (raw_hit, no freeze, no redirect): pc_en = 0, ifid_en = 0, idex_en = 1, idex_bubble = 1, exmem_en = memwb_en = 1; raw_stall = 1.
  - otherwise: all enables = 1; flush, bubble and raw_stall = 0.
- Scoreboard shift when !freeze:
  - tag_wb <= tag_mem; tag_mem <= tag_ex.
  - tag_ex <= invalid if (raw_stall | ex_redirect | !id_valid | !id_dst_vld), else {1, id_dst}.
  - Tag writes follow exactly the priority above.
- Latency: a dependent instruction stalls 3 cycles when RF_BYPASS = 0, 2 cycles when RF_BYPASS = 1, counted from the cycle the producer enters EX.
- stall_cnt: +1 each cycle where freeze | raw_stall; holds at all-ones (no wrap); never increments for redirect-only cycles.
- wait_cnt: counts cycles spent in MEM_WAIT and clears on leaving it. When wait_cnt reaches MEM_TIMEOUT-1 with mem_done low, mem_err sets and stays set until reset. The FSM keeps waiting.
- Reset (rst low, any time including mid-MEM_WAIT):
  - State: IDLE, tags invalid, wait_cnt = 0, stall_cnt = 0, mem_err = 0.
  - Outputs with idle inputs: all enables = 1, flush/bubble/raw_stall = 0.

Test Plan:
- RF_BYPASS = 0; producer id_dst = r3 is accepted, next ID has id_src1 = r3 -> raw_stall and idex_bubble high for exactly 3 cycles, pc_en = 0 during them, then released; stall_cnt = 3. Repeat with RF_BYPASS = 1 -> 2 cycles, stall_cnt = 2.
- mem_req = 1 with mem_done low for 4 cycles, then high -> all enables 0 for 4 cycles, FSM in MEM_WAIT, enables return to 1 on the mem_done cycle, stall_cnt += 4, tags unchanged across the freeze.
- ex_redirect = 1 in the same cycle as a raw_hit -> ifid_flush = 1, idex_bubble = 1, pc_en = 1, raw_stall = 0, tag_ex invalid, stall_cnt unchanged.
- freeze and ex_redirect together -> enables 0, ifid_flush = 0; on the following mem_done cycle the held redirect produces the flush.
- MEM_TIMEOUT = 8, mem_done never asserted -> mem_err rises after the 8th MEM_WAIT cycle and stays high; asserting rst mid-wait -> IDLE, mem_err = 0, stall_cnt = 0.
- id_src1 = r5 matching a valid tag_ex of r5 but id_src1_vld = 0 (or id_valid = 0) -> no stall.
